// File: rtl/hc595_frame_rx_pkg.sv
// Shared display constants for the 74HC595 common-anode display chain and its checker.
package hc595_frame_rx_pkg;

  localparam int DISP_FRAME_BITS = 16;

  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;
  localparam logic [7:0] DIG_ALL_OFF = 8'hFF;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef struct packed {
    logic [7:0] sel;
    logic [7:0] seg;
  } disp_frame_t;

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

endpackage

// File: rtl/hc595_frame_rx_pin_sync_edge.sv
// Multi-flop pin synchronizer with a history flop; gives the synced level and a one-clk rise pulse.
module pin_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], pin};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~hist_q;

endmodule

// File: rtl/hc595_frame_rx.sv
// Rebuilds the 16-bit sel/seg frame latched by the 74HC595 chain from its ds/shcp/stcp/oe pins.
module hc595_frame_rx
  import hc595_frame_rx_pkg::*;
#(
  parameter int FRAME_BITS  = DISP_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ds,
  input  logic       shcp,
  input  logic       stcp,
  input  logic       oe,
  output logic [7:0] sel_out,
  output logic [7:0] seg_out,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       blank,
  output logic [4:0] shift_cnt
);

  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);

  logic ds_s, shcp_s, stcp_s, oe_s;
  logic shcp_rise, stcp_rise;
  logic ds_rise_unused, oe_rise_unused, shcp_lvl_unused, stcp_lvl_unused;

  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ds (
    .clk(clk), .rst(rst), .pin(ds), .level(ds_s), .rise(ds_rise_unused));
  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_shcp (
    .clk(clk), .rst(rst), .pin(shcp), .level(shcp_s), .rise(shcp_rise));
  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_stcp (
    .clk(clk), .rst(rst), .pin(stcp), .level(stcp_s), .rise(stcp_rise));
  pin_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_oe (
    .clk(clk), .rst(rst), .pin(oe), .level(oe_s), .rise(oe_rise_unused));

  assign shcp_lvl_unused = shcp_s;
  assign stcp_lvl_unused = stcp_s;

  logic [DISP_FRAME_BITS-1:0] sr_q, sr_d;
  logic [4:0]                 cnt_q, cnt_d;
  disp_frame_t                out_q, out_d;
  logic                       valid_q, valid_d;
  logic                       err_q, err_d;

  // Latch is decided on the pre-shift register, matching the 595 storage stage lagging the shifter.
  always_comb begin
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (stcp_rise) begin
      if (cnt_q == FRAME_CNT) begin
        out_d.sel = sr_q[15:8];
        out_d.seg = sr_q[7:0];
        valid_d   = 1'b1;
      end else if (cnt_q != 5'd0) begin
        err_d = 1'b1;
      end
      cnt_d = 5'd0;
    end
    if (shcp_rise) begin
      sr_d  = {sr_q[DISP_FRAME_BITS-2:0], ds_s};
      cnt_d = sat_inc5(cnt_d);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q      <= '0;
      cnt_q     <= 5'd0;
      out_q.sel <= DIG_ALL_OFF;
      out_q.seg <= SEG_ALL_OFF;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign sel_out     = out_q.sel;
  assign seg_out     = out_q.seg;
  assign frame_valid = valid_q;
  assign frame_err   = err_q;
  assign blank       = oe_s;
  assign shift_cnt   = cnt_q;

endmodule

// File: tb/tb_hc595_frame_rx.sv
// Directed bench for hc595_frame_rx: drives the 595 pins like the display driver and by hand.
module tb_hc595_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ds = 1'b0, shcp = 1'b0, stcp = 1'b0, oe = 1'b0;
  logic [7:0] sel_out, seg_out;
  logic       frame_valid, frame_err, blank;
  logic [4:0] shift_cnt;

  int total = 0;
  int bad = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int v0, e0;

  always #10 clk = ~clk;

  hc595_frame_rx dut (
    .clk(clk), .rst(rst), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .sel_out(sel_out), .seg_out(seg_out), .frame_valid(frame_valid),
    .frame_err(frame_err), .blank(blank), .shift_cnt(shift_cnt));

  always @(posedge clk) begin
    #1;
    if (frame_valid) valid_cnt++;
    if (frame_err) err_cnt++;
    if (frame_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drv_bit(input logic b, input int hi, input int lo);
    ds = b;
    shcp = 1'b0;
    tick(lo);
    shcp = 1'b1;
    tick(hi);
  endtask

  // MSB first; shifts beyond 16 send zeros
  task automatic drv_shift(input logic [15:0] d, input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++)
      drv_bit((i < 16) ? d[15-i] : 1'b0, hi, lo);
    shcp = 1'b0;
    tick(lo);
  endtask

  task automatic pulse_stcp();
    stcp = 1'b1;
    tick(3);
    stcp = 1'b0;
    tick(4);
  endtask

  task automatic send_frame(input logic [15:0] d);
    drv_shift(d, 16, 2, 2);
    pulse_stcp();
  endtask

  initial begin
    tick(3);
    check("rst_sel", sel_out, 8'hFF);
    check("rst_seg", seg_out, 8'hFF);
    check("rst_valid", frame_valid, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_blank", blank, 1'b0);
    check("rst_cnt", shift_cnt, 5'd0);
    rst = 1'b0;
    tick(2);

    // stcp with no shifts, twice
    pulse_stcp();
    pulse_stcp();
    check("nosh_valid", valid_cnt, 0);
    check("nosh_err", err_cnt, 0);
    check("nosh_sel", sel_out, 8'hFF);
    check("nosh_seg", seg_out, 8'hFF);

    v0 = valid_cnt; e0 = err_cnt;
    send_frame(16'hFEC0);
    check("fe_sel", sel_out, 8'hFE);
    check("fe_seg", seg_out, 8'hC0);
    send_frame(16'hFEC0);
    check("fe_vcnt", valid_cnt - v0, 2);
    check("fe_ecnt", err_cnt - e0, 0);

    send_frame(16'h7F92);
    check("7f_sel", sel_out, 8'h7F);
    check("7f_seg", seg_out, 8'h92);
    send_frame(16'hBFF9);
    check("bf_sel", sel_out, 8'hBF);
    check("bf_seg", seg_out, 8'hF9);
    check("step_vcnt", valid_cnt - v0, 4);
    check("step_cnt0", shift_cnt, 5'd0);

    // short frame
    v0 = valid_cnt; e0 = err_cnt;
    drv_shift(16'hFFFF, 12, 3, 3);
    check("short_cnt12", shift_cnt, 5'd12);
    pulse_stcp();
    check("short_err", err_cnt - e0, 1);
    check("short_noval", valid_cnt - v0, 0);
    check("short_sel", sel_out, 8'hBF);
    check("short_seg", seg_out, 8'hF9);
    check("short_cnt0", shift_cnt, 5'd0);

    // clean frame with latency check
    v0 = valid_cnt;
    drv_shift(16'h01FF, 16, 3, 3);
    check("lat_cnt16", shift_cnt, 5'd16);
    stcp = 1'b1;
    tick(2);
    check("lat_old_sel", sel_out, 8'hBF);
    tick(1);
    check("lat_new_sel", sel_out, 8'h01);
    check("lat_new_seg", seg_out, 8'hFF);
    stcp = 1'b0;
    tick(4);
    check("01_valid", valid_cnt - v0, 1);

    // 17th shcp rise coincident with stcp
    v0 = valid_cnt; e0 = err_cnt;
    drv_shift(16'hA55A, 16, 3, 3);
    ds = 1'b1;
    tick(1);
    shcp = 1'b1;
    stcp = 1'b1;
    tick(3);
    shcp = 1'b0;
    stcp = 1'b0;
    tick(4);
    check("co_sel", sel_out, 8'hA5);
    check("co_seg", seg_out, 8'h5A);
    check("co_cnt1", shift_cnt, 5'd1);
    check("co_valid", valid_cnt - v0, 1);
    check("co_err", err_cnt - e0, 0);

    // saturation
    e0 = err_cnt; v0 = valid_cnt;
    drv_shift(16'h0000, 33, 2, 2);
    check("sat_cnt", shift_cnt, 5'd31);
    pulse_stcp();
    check("sat_err", err_cnt - e0, 1);
    check("sat_noval", valid_cnt - v0, 0);
    check("sat_sel", sel_out, 8'hA5);

    // reset mid-frame
    drv_shift(16'hFFFF, 8, 2, 2);
    check("mid_cnt8", shift_cnt, 5'd8);
    rst = 1'b1;
    #1;
    check("mid_rst_sel", sel_out, 8'hFF);
    check("mid_rst_seg", seg_out, 8'hFF);
    check("mid_rst_cnt", shift_cnt, 5'd0);
    tick(2);
    rst = 1'b0;
    tick(2);
    v0 = valid_cnt;
    send_frame(16'h3C0F);
    check("3c_sel", sel_out, 8'h3C);
    check("3c_seg", seg_out, 8'h0F);
    check("3c_valid", valid_cnt - v0, 1);

    // oe -> blank after 2 clk
    oe = 1'b1;
    tick(1);
    check("oe_b1", blank, 1'b0);
    tick(1);
    check("oe_b2", blank, 1'b1);
    check("oe_sel", sel_out, 8'h3C);
    check("oe_seg", seg_out, 8'h0F);
    oe = 1'b0;
    tick(2);
    check("oe_off", blank, 1'b0);

    check("never_both", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
